cic_mem_responder: RTL and testbench

- Memory-side responder for the CIC convolution engine. Holds the 64x64 grayscale input image and the five result banks that the engine reads and writes through csel.
- A host preloads the image through a write port and then raises ready. The block serves iaddr→idata reads while the engine holds busy high, and services cwr writes and crd reads per csel.
- It detects end of run when busy falls and exposes sticky protocol-error flags to the host.

---
 rtl/cic_pkg.sv | 43 ++++
 rtl/cic_ram_1w1r.sv | 39 +++
 rtl/cic_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_cic_mem_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC convolution memory responder:
// word/address widths, bank depths, bank select codes and FSM states.
package cic_pkg;

    localparam int DW        = 20;
    localparam int AW        = 12;
    localparam int IMG_DEPTH = 4096;
    localparam int L0_DEPTH  = 4096;
    localparam int L1_DEPTH  = 1024;
    localparam int L2_DEPTH  = 2048;

    typedef enum logic [2:0] {
        NSEL = 3'd0,
        L0K0 = 3'd1,
        L0K1 = 3'd2,
        L1K0 = 3'd3,
        L1K1 = 3'd4,
        L2F  = 3'd5
    } csel_e;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SERVE,
        DONE
    } rsp_state_e;

    // True when sel names a real bank and a lies inside that bank.
    function automatic logic addr_ok(
        input logic [2:0]    sel,
        input logic [AW-1:0] a
    );
        logic ok;
        unique case (sel)
            L0K0, L0K1: ok = 1'b1;
            L1K0, L1K1: ok = (a[11:10] == 2'b00);
            L2F:        ok = (a[11] == 1'b0);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cic_ram_1w1r.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value when no read is requested.
module cic_ram_1w1r
    import cic_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array contents are not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cic_mem_responder.sv
// Memory-side responder for the CIC engine: image store, five result
// banks, run-control FSM and sticky protocol-error flags.
module cic_mem_responder
    import cic_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          img_we,
    input  logic [AW-1:0] img_waddr,
    input  logic [DW-1:0] img_wdata,
    input  logic          img_load_done,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic [2:0]    csel,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    output logic          done,
    output logic [2:0]    err
);

    rsp_state_e state_q;
    logic       ready_q;
    logic       done_q;
    logic [2:0] err_q;
    logic [2:0] err_d;
    csel_e      rsel_q;

    logic       host_ok;
    logic       wr_ok;
    logic       rd_ok;
    logic       rd_go;
    logic [5:1] bank_we;
    logic [5:1] bank_re;
    logic [DW-1:0] bank_rd [1:5];

    assign host_ok = (state_q == IDLE) || (state_q == DONE);
    assign wr_ok   = addr_ok(csel, caddr_wr);
    assign rd_ok   = addr_ok(csel, caddr_rd);
    assign rd_go   = crd && !cwr;

    always_comb begin
        bank_we = '0;
        bank_re = '0;
        for (int b = 1; b <= 5; b++) begin
            bank_we[b] = cwr && wr_ok && (csel == 3'(b));
            bank_re[b] = rd_go && rd_ok && (csel == 3'(b));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (img_load_done) begin
                        state_q <= ARM;
                        ready_q <= 1'b1;
                    end
                end
                ARM: begin
                    if (busy) begin
                        state_q <= SERVE;
                        ready_q <= 1'b0;
                    end
                end
                SERVE: begin
                    if (!busy) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (img_load_done) begin
                        state_q <= ARM;
                        ready_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if ((cwr && !wr_ok) || (crd && !rd_ok)) begin
            err_d[0] = 1'b1;
        end
        if (cwr && crd) begin
            err_d[1] = 1'b1;
        end
        if (img_we && !host_ok) begin
            err_d[2] = 1'b1;
        end
    end

    // rsel_q remembers which bank fed the last read; NSEL forces zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q  <= '0;
            rsel_q <= NSEL;
        end else begin
            err_q <= err_d;
            if (rd_go) begin
                rsel_q <= rd_ok ? csel_e'(csel) : NSEL;
            end
        end
    end

    cic_ram_1w1r #(.DEPTH(IMG_DEPTH)) u_img (
        .clk     (clk),
        .reset   (reset),
        .we_i    (img_we && host_ok),
        .waddr_i (img_waddr),
        .wdata_i (img_wdata),
        .re_i    (state_q == SERVE),
        .raddr_i (iaddr),
        .rdata_o (idata)
    );

    cic_ram_1w1r #(.DEPTH(L0_DEPTH)) u_l0k0 (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we[1]),
        .waddr_i (caddr_wr),
        .wdata_i (cdata_wr),
        .re_i    (bank_re[1]),
        .raddr_i (caddr_rd),
        .rdata_o (bank_rd[1])
    );

    cic_ram_1w1r #(.DEPTH(L0_DEPTH)) u_l0k1 (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we[2]),
        .waddr_i (caddr_wr),
        .wdata_i (cdata_wr),
        .re_i    (bank_re[2]),
        .raddr_i (caddr_rd),
        .rdata_o (bank_rd[2])
    );

    cic_ram_1w1r #(.DEPTH(L1_DEPTH)) u_l1k0 (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we[3]),
        .waddr_i (caddr_wr[9:0]),
        .wdata_i (cdata_wr),
        .re_i    (bank_re[3]),
        .raddr_i (caddr_rd[9:0]),
        .rdata_o (bank_rd[3])
    );

    cic_ram_1w1r #(.DEPTH(L1_DEPTH)) u_l1k1 (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we[4]),
        .waddr_i (caddr_wr[9:0]),
        .wdata_i (cdata_wr),
        .re_i    (bank_re[4]),
        .raddr_i (caddr_rd[9:0]),
        .rdata_o (bank_rd[4])
    );

    cic_ram_1w1r #(.DEPTH(L2_DEPTH)) u_l2f (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we[5]),
        .waddr_i (caddr_wr[10:0]),
        .wdata_i (cdata_wr),
        .re_i    (bank_re[5]),
        .raddr_i (caddr_rd[10:0]),
        .rdata_o (bank_rd[5])
    );

    always_comb begin
        cdata_rd = '0;
        unique case (rsel_q)
            L0K0:    cdata_rd = bank_rd[1];
            L0K1:    cdata_rd = bank_rd[2];
            L1K0:    cdata_rd = bank_rd[3];
            L1K1:    cdata_rd = bank_rd[4];
            L2F:     cdata_rd = bank_rd[5];
            default: cdata_rd = '0;
        endcase
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_cic_mem_responder.sv
// Scoreboard bench for cic_mem_responder: a behavioural model predicts
// every registered output; a negedge monitor compares them.
module tb_cic_mem_responder;

    localparam int K_RDY = 0, K_DONE = 1, K_ERR = 2, K_IDATA = 3, K_CDATA = 4;
    localparam int S_IDLE = 0, S_ARM = 1, S_SERVE = 2, S_DONE = 3;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        img_we;
    logic [11:0] img_waddr;
    logic [19:0] img_wdata;
    logic        img_load_done;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic [2:0]  csel;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic        done;
    logic [2:0]  err;

    cic_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .img_we        (img_we),
        .img_waddr     (img_waddr),
        .img_wdata     (img_wdata),
        .img_load_done (img_load_done),
        .ready         (ready),
        .busy          (busy),
        .iaddr         (iaddr),
        .idata         (idata),
        .csel          (csel),
        .cwr           (cwr),
        .caddr_wr      (caddr_wr),
        .cdata_wr      (cdata_wr),
        .crd           (crd),
        .caddr_rd      (caddr_rd),
        .cdata_rd      (cdata_rd),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic [19:0] img_m [4096];
    bit          img_ok [4096];
    logic [19:0] bk_m [6][4096];
    int          m_st;
    logic        m_rdy;
    logic        m_done;
    logic [2:0]  m_err;
    logic [19:0] m_last;
    int          wl[$];
    int          tbl[11] = '{0, 1, 5, 6, 7, 1023, 1024, 1025, 2047, 2048, 4095};

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_RDY:   return "ready";
            K_DONE:  return "done";
            K_ERR:   return "err";
            K_IDATA: return "idata";
            default: return "cdata_rd";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RDY:   return {31'b0, ready};
            K_DONE:  return {31'b0, done};
            K_ERR:   return {29'b0, err};
            K_IDATA: return {12'b0, idata};
            default: return {12'b0, cdata_rd};
        endcase
    endfunction

    always @(negedge clk) begin : mon
        exp_t it;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            if (it.due != cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL stale_%s: due %0d seen %0d", kname(it.kind),
                         it.due, cyc);
            end else begin
                check(kname(it.kind), actual(it.kind), it.exp);
            end
        end
    end

    function automatic int depth(input int s);
        case (s)
            1, 2:    return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] v);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Predict the effect of the inputs about to be sampled at the next edge.
    task automatic model();
        int s;
        bit wv;
        bit rv;
        s  = int'(csel);
        wv = int'(caddr_wr) < depth(s);
        rv = int'(caddr_rd) < depth(s);
        if (m_st == S_SERVE && img_ok[iaddr]) push(K_IDATA, 32'(img_m[iaddr]));
        if (crd && cwr) m_err[1] = 1'b1;
        else if (crd) m_last = rv ? bk_m[s][caddr_rd] : 20'h0;
        if (crd) push(K_CDATA, 32'(m_last));
        if ((crd && !rv) || (cwr && !wv)) m_err[0] = 1'b1;
        if (cwr && wv) bk_m[s][caddr_wr] = cdata_wr;
        if (img_we) begin
            if (m_st == S_IDLE || m_st == S_DONE) begin
                img_m[img_waddr]  = img_wdata;
                img_ok[img_waddr] = 1'b1;
            end else begin
                m_err[2] = 1'b1;
            end
        end
        case (m_st)
            S_IDLE:  if (img_load_done) begin m_st = S_ARM; m_rdy = 1; end
            S_ARM:   if (busy) begin m_st = S_SERVE; m_rdy = 0; end
            S_SERVE: if (!busy) begin m_st = S_DONE; m_done = 1; end
            default: if (img_load_done) begin
                         m_st = S_ARM; m_rdy = 1; m_done = 0;
                     end
        endcase
        push(K_RDY, {31'b0, m_rdy});
        push(K_DONE, {31'b0, m_done});
        push(K_ERR, {29'b0, m_err});
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        img_we        = 1'b0;
        img_load_done = 1'b0;
        cwr           = 1'b0;
        crd           = 1'b0;
    endtask

    task automatic model_reset();
        m_st   = S_IDLE;
        m_rdy  = 1'b0;
        m_done = 1'b0;
        m_err  = 3'b0;
        m_last = 20'h0;
    endtask

    task automatic host_write(input int a, input logic [19:0] d);
        img_we    = 1'b1;
        img_waddr = 12'(a);
        img_wdata = d;
        step();
    endtask

    task automatic bwr(input int s, input int a, input logic [19:0] d);
        csel     = 3'(s);
        cwr      = 1'b1;
        caddr_wr = 12'(a);
        cdata_wr = d;
        step();
    endtask

    task automatic brd(input int s, input int a);
        csel     = 3'(s);
        crd      = 1'b1;
        caddr_rd = 12'(a);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, ready}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
        check({tag, "_err"}, {29'b0, err}, 32'h0);
        check({tag, "_idata"}, {12'b0, idata}, 32'h0);
        check({tag, "_cdata"}, {12'b0, cdata_rd}, 32'h0);
    endtask

    initial begin
        int a;
        int r;
        reset         = 1'b1;
        img_we        = 1'b0;
        img_waddr     = '0;
        img_wdata     = '0;
        img_load_done = 1'b0;
        busy          = 1'b0;
        iaddr         = '0;
        csel          = '0;
        cwr           = 1'b0;
        caddr_wr      = '0;
        cdata_wr      = '0;
        crd           = 1'b0;
        caddr_rd      = '0;
        model_reset();
        #3;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Give every bank a known value at each table address it holds.
        for (int s = 1; s <= 5; s++) begin
            for (int i = 0; i < 11; i++) begin
                if (tbl[i] < depth(s)) bwr(s, tbl[i], 20'($urandom));
            end
        end

        host_write(0, 20'h000AB);
        host_write(4095, 20'h000FF);
        wl.push_back(0);
        wl.push_back(4095);
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(1, 4094));
            host_write(a, 20'($urandom));
            wl.push_back(a);
        end
        img_load_done = 1'b1;
        step();
        busy = 1'b1;
        step();

        iaddr = 12'd0;
        step();
        iaddr = 12'd4095;
        step();
        for (int i = 0; i < 20; i++) begin
            iaddr = 12'(wl[$urandom_range(0, wl.size() - 1)]);
            step();
        end

        bwr(1, 5, 20'hF8F71);
        brd(1, 5);
        bwr(2, 5, 20'h12345);
        brd(2, 5);
        bwr(3, 1024, 20'hABCDE);
        brd(3, 1024);
        brd(3, 0);
        csel     = 3'd1;
        cwr      = 1'b1;
        caddr_wr = 12'd6;
        cdata_wr = 20'h55555;
        crd      = 1'b1;
        caddr_rd = 12'd7;
        step();
        brd(1, 6);

        iaddr = 12'd0;
        host_write(0, 20'h12345);
        step();
        step();

        for (int i = 0; i < 300; i++) begin
            iaddr = 12'(wl[$urandom_range(0, wl.size() - 1)]);
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                r    = int'($urandom_range(0, 2));
                csel = (r == 0) ? 3'd0 : ((r == 1) ? 3'd6 : 3'd7);
            end else begin
                csel = 3'($urandom_range(1, 5));
            end
            caddr_wr = 12'(tbl[$urandom_range(0, 10)]);
            caddr_rd = 12'(tbl[$urandom_range(0, 10)]);
            cdata_wr = 20'($urandom);
            r = int'($urandom_range(0, 9));
            cwr = (r <= 3) || (r == 8);
            crd = (r >= 4 && r <= 8);
            step();
        end

        busy = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 6; i++) begin
            brd(int'($urandom_range(1, 5)), tbl[$urandom_range(0, 10)]);
        end

        host_write(100, 20'h0BEEF);
        wl.push_back(100);
        img_load_done = 1'b1;
        step();
        busy = 1'b1;
        step();
        iaddr = 12'd100;
        step();
        step();

        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 32'h0);
        sb.delete();
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_serve");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        busy = 1'b0;
        for (int i = 0; i < 3; i++) step();

        @(negedge clk);
        #1;
        check("sb_final", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
